mux_nin_1out_reg: RTL and testbench

Parametrised N-input, 1-output registered multiplexer with a per-channel valid/ready handshake. It is the pipelined successor to the combinational 2:1 datapath mux. Two selection modes:
- Fixed select, steered by `sel`.
- Round-robin arbitration among valid inputs.
It sits between pipeline stages where several producers share one consumer, e.g. the writeback source or a shared memory port.

---
 rtl/mux_defs.sv | 16 +
 rtl/rr_arbiter_n.sv | 34 +++
 rtl/mux_nin_1out_reg.sv | 94 +++++++++
 tb/tb_mux_nin_1out_reg.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mux_defs.sv
// Shared constants and helpers for the registered N:1 mux family.
package mux_defs;

  localparam logic MODO_FIJO = 1'b0;
  localparam logic MODO_RR   = 1'b1;

  // Bits needed to encode v distinct values (v >= 2).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++)
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational rotating-priority arbiter: first request at or after ptr wins.
module rr_arbiter_n #(
  parameter int unsigned NIN  = 4,
  parameter int unsigned SELW = 2
) (
  input  logic [NIN-1:0]  req,
  input  logic [SELW-1:0] ptr,
  input  logic            en,
  output logic [NIN-1:0]  gnt,
  output logic [SELW-1:0] idx,
  output logic            any_grant
);

  always_comb begin
    int unsigned c;
    logic [SELW-1:0] ci;
    gnt       = '0;
    idx       = '0;
    any_grant = 1'b0;
    c         = 0;
    ci        = '0;
    for (int unsigned k = 0; k < NIN; k++) begin
      c = 32'(ptr) + k;
      if (c >= NIN) c = c - NIN;
      ci = SELW'(c);
      if (en && !any_grant && req[ci]) begin
        any_grant = 1'b1;
        gnt[ci]   = 1'b1;
        idx       = ci;
      end
    end
  end

endmodule

// File: rtl/mux_nin_1out_reg.sv
// Registered N:1 mux with valid/ready per channel, fixed-select or round-robin.
// Optional registered even-parity output when MUX_PARIDAD_EN is defined.
module mux_nin_1out_reg
  import mux_defs::*;
#(
  parameter int unsigned DB   = 32,
  parameter int unsigned NIN  = 4,
  parameter int unsigned SELW = clog2(NIN)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NIN*DB-1:0] datos_in,
  input  logic [NIN-1:0]    valid_in,
  output logic [NIN-1:0]    ready_in,
  input  logic [SELW-1:0]   sel,
  input  logic              modo,
  output logic [DB-1:0]     salida,
  output logic [SELW-1:0]   canal_out,
  output logic              valid_out,
  input  logic              ready_out
`ifdef MUX_PARIDAD_EN
  ,
  output logic              paridad_out
`endif
);

  logic            en;
  logic            sel_ok;
  logic [NIN-1:0]  req;
  logic [NIN-1:0]  gnt;
  logic [SELW-1:0] g_idx;
  logic            any_g;
  logic [SELW-1:0] ptr;
  logic [DB-1:0]   dato_g;

  assign en     = !valid_out || ready_out;
  assign sel_ok = 32'(sel) < NIN;

  // Fixed mode reuses the arbiter by presenting at most one request.
  always_comb begin
    req = '0;
    if (modo == MODO_RR) begin
      req = valid_in;
    end else begin
      for (int unsigned i = 0; i < NIN; i++)
        req[i] = valid_in[i] && sel_ok && (sel == SELW'(i));
    end
  end

  rr_arbiter_n #(
    .NIN  (NIN),
    .SELW (SELW)
  ) u_arb (
    .req       (req),
    .ptr       (ptr),
    .en        (en && reset_n),
    .gnt       (gnt),
    .idx       (g_idx),
    .any_grant (any_g)
  );

  assign ready_in = gnt;

  always_comb begin
    dato_g = '0;
    for (int unsigned i = 0; i < NIN; i++)
      if (gnt[i]) dato_g = datos_in[i*DB +: DB];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      salida    <= '0;
      canal_out <= '0;
      valid_out <= 1'b0;
      ptr       <= '0;
    end else if (any_g) begin
      salida    <= dato_g;
      canal_out <= g_idx;
      valid_out <= 1'b1;
      if (modo == MODO_RR)
        ptr <= (g_idx == SELW'(NIN - 1)) ? '0 : g_idx + 1'b1;
    end else if (ready_out) begin
      valid_out <= 1'b0;
    end
  end

`ifdef MUX_PARIDAD_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   paridad_out <= 1'b0;
    else if (any_g) paridad_out <= ^dato_g;
  end
`endif

endmodule

// File: tb/tb_mux_nin_1out_reg.sv
// Bench for mux_nin_1out_reg: 4-channel reference model plus a 6-channel instance for out-of-range sel.
module tb_mux_nin_1out_reg;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [127:0] datos;
  logic [3:0]   valid_in, ready_in;
  logic [1:0]   sel;
  logic         modo, ready_out, valid_out;
  logic [31:0]  salida;
  logic [1:0]   canal_out;

  logic [191:0] d6;
  logic [5:0]   v6, r6;
  logic [2:0]   s6, can6;
  logic         modo6, ro6, vo6;
  logic [31:0]  sal6;
`ifdef MUX_PARIDAD_EN
  logic         paridad_out, par6;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_nin_1out_reg #(.DB(32), .NIN(4)) dut (
    .clk(clk), .reset_n(reset_n), .datos_in(datos), .valid_in(valid_in),
    .ready_in(ready_in), .sel(sel), .modo(modo), .salida(salida),
    .canal_out(canal_out), .valid_out(valid_out), .ready_out(ready_out)
`ifdef MUX_PARIDAD_EN
    , .paridad_out(paridad_out)
`endif
  );

  mux_nin_1out_reg #(.DB(32), .NIN(6)) dut6 (
    .clk(clk), .reset_n(reset_n), .datos_in(d6), .valid_in(v6),
    .ready_in(r6), .sel(s6), .modo(modo6), .salida(sal6),
    .canal_out(can6), .valid_out(vo6), .ready_out(ro6)
`ifdef MUX_PARIDAD_EN
    , .paridad_out(par6)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Winning channel from the selection rules, -1 when nothing is eligible.
  function automatic int exp_grant(input logic md, input logic [1:0] s,
                                   input logic [3:0] v, input int p);
    if (!md) return v[s] ? int'(s) : -1;
    for (int k = 0; k < 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  logic [31:0] m_sal;
  int          m_can, m_ptr;
  logic        m_valid, m_par;

  always @(posedge clk or negedge reset_n) begin
    int g;
    if (!reset_n) begin
      m_sal = 0; m_can = 0; m_valid = 0; m_ptr = 0; m_par = 0;
    end else begin
      g = exp_grant(modo, sel, valid_in, m_ptr);
      if ((!m_valid || ready_out) && g >= 0) begin
        m_sal   = datos[g*32 +: 32];
        m_can   = g;
        m_valid = 1;
        m_par   = ^m_sal;
        if (modo) m_ptr = (g + 1) % 4;
      end else if (ready_out) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    logic [3:0] er;
    g  = exp_grant(modo, sel, valid_in, m_ptr);
    er = '0;
    if (reset_n && (!m_valid || ready_out) && g >= 0) er[g] = 1'b1;
    chk("m_ready_in", 64'(ready_in), 64'(er));
    chk("m_salida", 64'(salida), 64'(m_sal));
    chk("m_canal_out", 64'(canal_out), 64'(m_can));
    chk("m_valid_out", 64'(valid_out), 64'(m_valid));
`ifdef MUX_PARIDAD_EN
    chk("m_paridad", 64'(paridad_out), 64'(m_par));
`endif
  end

  initial begin
    logic [3:0] pats [3];
    pats = '{4'b0110, 4'b1111, 4'b0010};
    for (int i = 0; i < 4; i++) datos[i*32 +: 32] = 32'hCAFE0000 + i;
    for (int i = 0; i < 6; i++) d6[i*32 +: 32] = 32'hD6000000 + i;
    reset_n = 0; valid_in = 4'hF; sel = 0; modo = 0; ready_out = 1;
    v6 = 0; s6 = 0; modo6 = 0; ro6 = 1;

    @(negedge clk);
    chk("rst_ready_in", 64'(ready_in), 0);
    chk("rst_valid_out", 64'(valid_out), 0);
    chk("rst_salida", 64'(salida), 0);
    #2 reset_n = 1; modo = 0; sel = 2; valid_in = 4'b0100; ready_out = 1;
    s6 = 6; v6 = 6'h3F;
    #1 chk("fix_ready", 64'(ready_in), 4'b0100);
    chk("sel6_ready", 64'(r6), 0);

    @(negedge clk);
    chk("fix_salida", 64'(salida), 32'hCAFE0002);
    chk("fix_canal", 64'(canal_out), 2);
    chk("fix_valid", 64'(valid_out), 1);
    chk("sel6_novalid", 64'(vo6), 0);
    #2 valid_in = 0; s6 = 7;
    #1 chk("sel7_ready", 64'(r6), 0);

    @(negedge clk);
    chk("drain_valid", 64'(valid_out), 0);
    chk("drain_hold", 64'(salida), 32'hCAFE0002);
    chk("sel7_novalid", 64'(vo6), 0);
    #2 s6 = 1;
    #1 chk("sel1_ready", 64'(r6), 6'b000010);

    @(negedge clk);
    chk("sel1_canal", 64'(can6), 1);
    chk("sel1_salida", 64'(sal6), 32'hD6000001);
    chk("sel1_valid", 64'(vo6), 1);
    #2 s6 = 5;
    #1 chk("sel5_ready", 64'(r6), 6'b100000);

    @(negedge clk);
    chk("sel5_canal", 64'(can6), 5);
    #2 v6 = 0; modo = 1; valid_in = 4'hF;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_seq", 64'(canal_out), 64'(k % 4));
    end
    #2 valid_in = 4'b0001;
    @(negedge clk);
    chk("rr_only0", 64'(canal_out), 0);
    #2 valid_in = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_alt", 64'(canal_out), (k % 2 == 0) ? 3 : 0);
    end

    #2 ready_out = 0;
    #1 chk("bp_ready0", 64'(ready_in), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_salida", 64'(salida), 32'hCAFE0000);
      chk("bp_canal", 64'(canal_out), 0);
      chk("bp_valid", 64'(valid_out), 1);
      #2 valid_in = pats[k];
      #1 chk("bp_ready", 64'(ready_in), 0);
    end
    @(negedge clk);
    #2 ready_out = 1;
    #1 chk("rel_ready", 64'(ready_in), 4'b0010);
    @(negedge clk);
    chk("rel_canal", 64'(canal_out), 1);
    chk("rel_salida", 64'(salida), 32'hCAFE0001);
    #2 valid_in = 4'hF;
    @(negedge clk);
    chk("pre_rst_canal", 64'(canal_out), 2);

    #2 reset_n = 0;
    #1 chk("arst_valid", 64'(valid_out), 0);
    chk("arst_salida", 64'(salida), 0);
    chk("arst_ready", 64'(ready_in), 0);
    @(negedge clk);
    #2 reset_n = 1;
    @(negedge clk);
    chk("restart_canal", 64'(canal_out), 0);
    chk("restart_salida", 64'(salida), 32'hCAFE0000);
    #2 datos[32 +: 32] = 32'h00000007;
    @(negedge clk);
    chk("par_salida", 64'(salida), 32'h00000007);
    chk("par_canal", 64'(canal_out), 1);
`ifdef MUX_PARIDAD_EN
    chk("par_bit", 64'(paridad_out), 1);
`endif
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
